// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Owns the program counter and the IF/ID pipeline register. The current pc is
//   presented on imem_addr; the combinational word returned on imem_instr is
//   captured into IF/ID together with pc and pc+PC_STEP on an advancing edge.
//   Handles stall, flush, branch redirect and out-of-range fetch faults.
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : synchronous active-low reset
//   stall          : hold pc and IF/ID
//   flush          : squash IF/ID (valid cleared, other fields held)
//   branch_taken   : redirect pc to branch_target (word aligned)
//   branch_target  : byte address of the redirect
//   imem_addr      : byte address to instruction memory (= pc)
//   imem_instr     : instruction word returned for imem_addr
//   if_id_valid    : IF/ID holds a live instruction
//   if_id_pc       : pc of the held instruction
//   if_id_pc_plus4 : if_id_pc + PC_STEP
//   if_id_instr    : held instruction word
//   fetch_fault    : pc out of range, fetch suspended
//   misalign       : sticky flag, some branch_target had [1:0] != 0
//   fetch_count    : number of instructions issued into IF/ID
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned PC_STEP    = 4,
  parameter int unsigned IMEM_WORDS = 1280
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        fetch_fault,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] STEP     = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;

  logic [31:0] pc_next_seq_s;
  logic [31:0] target_aligned_s;
  logic        target_misaligned_s;
  logic        target_in_range_s;
  logic        pc_in_range_s;

  // Derived address terms for the current pc and the redirect target.
  always_comb begin
    pc_next_seq_s       = pc_r + STEP;
    target_aligned_s    = {branch_target[31:2], 2'b00};
    target_misaligned_s = (branch_target[1:0] != 2'b00);
    target_in_range_s   = (target_aligned_s < PC_LIMIT);
    pc_in_range_s       = (pc_r < PC_LIMIT);
  end

  assign imem_addr   = pc_r;
  assign fetch_fault = (state_r == S_FAULT);

  // Fetch sequencer: pc, IF/ID register, status flags and issue counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= S_BOOT;
      pc_r           <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_pc       <= 32'h0000_0000;
      if_id_pc_plus4 <= 32'h0000_0000;
      if_id_instr    <= 32'h0000_0000;
      misalign       <= 1'b0;
      fetch_count    <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_BOOT: begin
          // One bubble cycle so memory sees RESET_PC before the first capture.
          state_r <= S_RUN;
        end
        S_RUN: begin
          if (branch_taken) begin
            pc_r        <= target_aligned_s;
            if_id_valid <= 1'b0;
            misalign    <= misalign | target_misaligned_s;
          end else if (flush) begin
            if_id_valid <= 1'b0;
          end else if (stall) begin
            if_id_valid <= if_id_valid;
          end else if (!pc_in_range_s) begin
            // The pc being fetched is illegal: suspend without capturing.
            state_r     <= S_FAULT;
            if_id_valid <= 1'b0;
          end else begin
            if_id_valid    <= 1'b1;
            if_id_pc       <= pc_r;
            if_id_pc_plus4 <= pc_next_seq_s;
            if_id_instr    <= imem_instr;
            pc_r           <= pc_next_seq_s;
            fetch_count    <= fetch_count + 32'd1;
          end
        end
        S_FAULT: begin
          if (branch_taken) begin
            misalign <= misalign | target_misaligned_s;
            // Only a legal target restarts fetching; otherwise stay parked.
            if (target_in_range_s) begin
              pc_r    <= target_aligned_s;
              state_r <= S_RUN;
            end else begin
              pc_r    <= pc_r;
            end
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          state_r     <= S_BOOT;
          if_id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] LIMIT = 32'h0000_1400;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_instr;
  logic        if_id_valid, fetch_fault, misalign;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;

  logic [31:0] mem [0:1279];

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Reference model state (plain behavioural variables)
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  bit          m_boot, m_fault, m_valid, m_mis;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .fetch_fault(fetch_fault), .misalign(misalign), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational word read, junk outside the legal range.
  always_comb begin
    if (imem_addr < LIMIT) imem_instr = mem[int'(imem_addr >> 2)];
    else                   imem_instr = 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one architectural step per rising edge.
  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = {branch_target[31:2], 2'b00};
    if (!rst_n) begin
      m_pc = 32'h0; m_boot = 1; m_fault = 0; m_valid = 0;
      m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_mis = 0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_fault) begin
      if (branch_taken) begin
        if (branch_target[1:0] != 2'b00) m_mis = 1;
        if (tgt < LIMIT) begin m_pc = tgt; m_fault = 0; end
      end
    end else if (branch_taken) begin
      if (branch_target[1:0] != 2'b00) m_mis = 1;
      m_pc = tgt; m_valid = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (m_pc >= LIMIT) begin
      m_fault = 1; m_valid = 0;
    end else begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem[int'(m_pc >> 2)];
      m_valid = 1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      chk("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
      chk("count", fetch_count, m_cnt);
      if (m_valid) begin
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_pc4", if_id_pc_plus4, m_ipc4);
        chk("if_id_instr", if_id_instr, m_instr);
      end
    end
  end

  // Drive inputs for the next edge, then settle just past that edge.
  task automatic step(input bit br, input logic [31:0] tgt, input bit st, input bit fl);
    branch_taken = br; branch_target = tgt; stall = st; flush = fl;
    @(posedge clk); #2;
  endtask

  initial begin
    for (int i = 0; i < 1280; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0010_2103;
    rst_n = 1'b0; stall = 0; flush = 0; branch_taken = 0; branch_target = 32'h0;
    step(0, 0, 0, 0);
    check_en = 1'b1;
    step(0, 0, 0, 0);
    chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_count", fetch_count, 32'h0);
    rst_n = 1'b1;

    // 1: bubble then sequential fetch
    step(0, 0, 0, 0);
    chk("t1_bubble_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("t1_instr0", if_id_instr, 32'h0000_2083);
    chk("t1_pc0", if_id_pc, 32'h0);
    step(0, 0, 0, 0);
    chk("t1_instr1", if_id_instr, 32'h0010_2103);
    chk("t1_pc1", if_id_pc, 32'h4);
    chk("t1_pc1p4", if_id_pc_plus4, 32'h8);
    chk("t1_count", fetch_count, 32'd2);

    // 2: stall for three cycles at pc=8
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      chk("t2_addr", imem_addr, 32'h8);
      chk("t2_pc", if_id_pc, 32'h4);
      chk("t2_count", fetch_count, 32'd2);
    end
    step(0, 0, 0, 0);
    chk("t2_resume_pc", if_id_pc, 32'h8);
    chk("t2_resume_instr", if_id_instr, mem[2]);

    // 3: branch with stall
    step(1, 32'h28, 1, 0);
    chk("t3_addr", imem_addr, 32'h28);
    chk("t3_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("t3_pc", if_id_pc, 32'h28);

    // 4: misaligned target, sticky flag
    step(1, 32'h2A, 0, 0);
    chk("t4_addr", imem_addr, 32'h28);
    chk("t4_mis", {31'd0, misalign}, 32'd1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t4_mis_sticky", {31'd0, misalign}, 32'd1);

    // 5: last legal word, fault, recovery
    step(1, 32'h13FC, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_last_pc", if_id_pc, 32'h13FC);
    chk("t5_last_valid", {31'd0, if_id_valid}, 32'd1);
    chk("t5_addr", imem_addr, 32'h1400);
    step(0, 0, 0, 0);
    chk("t5_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t5_fault_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("t5_fault_hold", imem_addr, 32'h1400);
    step(1, 32'h0, 0, 0);
    chk("t5_fault_clr", {31'd0, fetch_fault}, 32'd0);
    step(0, 0, 0, 0);
    chk("t5_issue_pc", if_id_pc, 32'h0);
    chk("t5_issue_instr", if_id_instr, 32'h0000_2083);

    // 6: reset overrides flush and branch
    rst_n = 1'b0;
    step(1, 32'h100, 0, 1);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t6_pc", if_id_pc, 32'h0);
    chk("t6_instr", if_id_instr, 32'h0);
    chk("t6_mis", {31'd0, misalign}, 32'd0);
    chk("t6_count", fetch_count, 32'h0);
    rst_n = 1'b1;

    // Randomized phase against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 32'h1500),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
